muldiv_controller: RTL and testbench
====================================

// Module: muldiv_controller
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns HI/LO architectural registers.
//  Replaces the combinational multiply/divide path beside the ALU; the decode/execute stage issues ops
//  through a valid/ready handshake and stalls MFHI/MFLO on hilo_valid.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO each WIDTH bits, product 2*WIDTH
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  reset       in   1      synchronous, active-high
//  op_valid    in   1      op request
//  op_ready    out  1      controller idle, can accept
//  op_code     in   3      muldiv_pkg::muldiv_op_t (MULT,MULTU,DIV,DIVU,MTHI,MTLO)
//  rs_content  in   WIDTH  dividend / multiplicand / MTxx source
//  rt_content  in   WIDTH  divisor / multiplier
//  flush       in   1      cancel in-flight op (exception/branch squash)
//  hi, lo      out  WIDTH  architectural HI/LO
//  hilo_valid  out  1      hi/lo hold committed results (low while busy)
//  done        out  1      one-cycle pulse after HI/LO commit
// BEHAVIOUR
//  Reset: state IDLE, hi=lo=0, op_ready=1, hilo_valid=1, done=0, counter=0.
//  Accept when op_valid&&op_ready at an edge; operands latched; op_valid ignored while op_ready=0.
//  States: IDLE -> MUL_RUN | DIV_RUN -> FIXUP -> IDLE. MTHI/MTLO: write at accept edge, stay IDLE.
//  Signed ops: operands converted to magnitudes at accept; signs recorded for FIXUP.
//  MUL_RUN: shift-add, one bit/cycle, 6-bit counter 0..WIDTH-1, then FIXUP.
//  DIV_RUN: restoring division, one quotient bit/cycle, WIDTH cycles, then FIXUP.
//  FIXUP: negate product if signs differ; quotient negated if signs differ, remainder takes dividend
//   sign; HI/LO written at FIXUP exit edge; done=1 and op_ready=1 the following cycle.
//  Latency: accept edge N -> HI/LO updated at edge N+WIDTH+1 (33 for WIDTH=32); MTxx: edge N.
//  op_ready=0, hilo_valid=0 from accept edge until commit edge.
//  Divide by zero: skip DIV_RUN, FIXUP next cycle: LO=all-ones, HI=rs_content. Latency 2.
//  Signed overflow 0x80000000/-1: LO=0x80000000, HI=0 (natural result of magnitude path; no trap).
//  flush: in any non-IDLE state -> IDLE next edge, HI/LO unchanged, no done. flush with op_valid in
//   IDLE: flush wins, op not accepted. flush in the FIXUP cycle still cancels the commit.
//  reset mid-op: identical to reset; in-flight op discarded.
//  New op back-to-back: accepted in the done cycle (op_ready=1 there).
// CONFIGURATION
//  MULDIV_FAST_MULT_EN defined: MUL_RUN lasts 1 cycle using a single WIDTH x WIDTH multiplier;
//   MULT/MULTU commit at accept edge N+2. Undefined: iterative shift-add as above.
//  Division is always iterative; flush/reset rules unchanged in both builds.
// STRUCTURE
//  muldiv_pkg: muldiv_op_t enum, muldiv_state_t enum, MULDIV_CNT_W=6 constant.
//  Sub-module muldiv_div_step: combinational one-bit restoring step
//   (rem_in, quo_in, divisor -> rem_out, quo_out); instantiated once, driven by DIV_RUN.
//  Multiply step, sign handling, FSM and HI/LO registers are in the top module.
// TESTING
//  MULT rs=0xFFFFFFFE rt=3 -> HI=0xFFFFFFFF LO=0xFFFFFFFA, commit at N+33 (N+2 with FAST_MULT).
//  DIVU 100/7 -> LO=14 HI=2; DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//  DIV 5/0 -> LO=0xFFFFFFFF HI=5 at N+2; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
//  MTHI 0x1234, MTLO 0x5678, MULTU, flush at cycle 10 -> HI=0x1234 LO=0x5678, done never, op_ready next cycle.
//  reset in DIV_RUN cycle 5 -> HI=LO=0, op_ready=1; op_valid held while busy -> not accepted twice.
//  Back-to-back MULTU 0xFFFFFFFF*0xFFFFFFFF then DIVU -> HI=0xFFFFFFFE LO=1, DIVU accepted in done cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and counter width for the multiply/divide controller
package muldiv_pkg;
    localparam int MULDIV_CNT_W = 6;
    typedef enum logic [2:0] {MULT, MULTU, DIV, DIVU, MTHI, MTLO} muldiv_op_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_FIXUP} muldiv_state_t;
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step producing one quotient bit
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH:0] shifted, diff;
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/muldiv_controller.sv
// muldiv_controller: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO; MULDIV_FAST_MULT_EN selects a one-cycle multiplier
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  muldiv_op_t       op_code,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hilo_valid,
    output logic             done
);
    muldiv_state_t state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt;
    logic [WIDTH-1:0] upper, lower, operand, rem_nx, quo_nx, rs_mag, rt_mag, hi_src;
    logic [2*WIDTH-1:0] prod_fix;
    logic neg_res, neg_rem, div_op, rs_neg, rt_neg, is_signed, is_mul, is_div, accept, last, div_zero;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, operand} * {{WIDTH{1'b0}}, lower};
`else
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
`endif
    assign op_ready   = state_q == S_IDLE;
    assign hilo_valid = op_ready;
    assign accept     = op_valid && op_ready && !flush;
    assign is_signed  = op_code == MULT || op_code == DIV;
    assign is_mul     = op_code == MULT || op_code == MULTU;
    assign is_div     = op_code == DIV || op_code == DIVU;
    assign rs_neg     = is_signed && rs_content[WIDTH-1];
    assign rt_neg     = is_signed && rt_content[WIDTH-1];
    assign rs_mag     = rs_neg ? -rs_content : rs_content;
    assign rt_mag     = rt_neg ? -rt_content : rt_content;
    assign last       = cnt == MULDIV_CNT_W'(WIDTH - 1);
    assign div_zero   = operand == '0;
    assign prod_fix   = neg_res ? -{upper, lower} : {upper, lower};
    assign hi_src     = div_zero ? lower : upper;

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in (upper),
        .quo_in (lower),
        .divisor(operand),
        .rem_out(rem_nx),
        .quo_out(quo_nx)
    );

    // State register
    always_ff @(posedge clk)
        state_q <= reset ? S_IDLE : state_d;

    // Next state; a flush squashes any state back to idle, even the commit cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = !accept ? S_IDLE : is_mul ? S_MUL_RUN : is_div ? S_DIV_RUN : S_IDLE;
`ifdef MULDIV_FAST_MULT_EN
            S_MUL_RUN: state_d = S_FIXUP;
`else
            S_MUL_RUN: state_d = last ? S_FIXUP : S_MUL_RUN;
`endif
            S_DIV_RUN: state_d = (div_zero || last) ? S_FIXUP : S_DIV_RUN;
            default:   state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Datapath: latch magnitudes at accept, iterate, then sign-fix and commit HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            upper   <= '0;
            lower   <= '0;
            operand <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div_op  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= state_q == S_FIXUP && !flush;
            cnt  <= (state_q == S_IDLE) ? '0 : cnt + 1'b1;
            if (accept) begin
                upper   <= '0;
                lower   <= rs_mag;
                operand <= rt_mag;
                neg_res <= rs_neg ^ rt_neg;
                neg_rem <= rs_neg;
                div_op  <= is_div;
                if (op_code == MTHI) hi <= rs_content;
                if (op_code == MTLO) lo <= rs_content;
            end
`ifdef MULDIV_FAST_MULT_EN
            if (state_q == S_MUL_RUN) {upper, lower} <= prod;
`else
            if (state_q == S_MUL_RUN) {upper, lower} <= {mul_sum, lower[WIDTH-1:1]};
`endif
            if (state_q == S_DIV_RUN && !div_zero) begin
                upper <= rem_nx;
                lower <= quo_nx;
            end
            if (state_q == S_FIXUP && !flush) begin
                lo <= !div_op ? prod_fix[WIDTH-1:0] : div_zero ? '1 : neg_res ? -lower : lower;
                hi <= !div_op ? prod_fix[2*WIDTH-1:WIDTH] : neg_rem ? -hi_src : hi_src;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_controller.sv
// tb_muldiv_controller: scoreboard bench for the multiply/divide controller
module tb_muldiv_controller;
    import muldiv_pkg::*;
    localparam int W = 32;

    logic clk = 1'b0, reset = 1'b1, op_valid = 1'b0, flush = 1'b0;
    muldiv_op_t op_code = MULT;
    logic [W-1:0] rs_content = '0, rt_content = '0;
    logic op_ready, hilo_valid, done;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, fails = 0, cyc = 0;
    logic [31:0] mhi = '0, mlo = '0;

    muldiv_controller #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .rs_content(rs_content), .rt_content(rt_content), .flush(flush),
        .hi(hi), .lo(lo), .hilo_valid(hilo_valid), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        int q, r;
        case (op)
            MULT: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                return 64'(pa * pb);
            end
            MULTU: return {32'b0, a} * {32'b0, b};
            DIVU: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic int lat(input muldiv_op_t op, input logic [31:0] b);
        if (op == DIV || op == DIVU) return (b == 0) ? 2 : 33;
`ifdef MULDIV_FAST_MULT_EN
        return 2;
`else
        return 33;
`endif
    endfunction

    // Commit monitor: every done pulse must match the oldest expected result and cycle
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (hi !== mon_e.hi || lo !== mon_e.lo) begin
                    fails++;
                    $display("FAIL commit_value got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, mon_e.hi, mon_e.lo);
                end
                checks++;
                if (cyc !== mon_e.cyc) begin
                    fails++;
                    $display("FAIL commit_cycle got %0d expected %0d", cyc, mon_e.cyc);
                end
                mhi = mon_e.hi;
                mlo = mon_e.lo;
            end
        end
    end

    task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        logic [63:0] r;
        while (!op_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (op_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_ready got op_ready=%b expected 1", op_ready);
        end
        op_code = op;
        rs_content = a;
        rt_content = b;
        op_valid = 1'b1;
        if (op == MTHI) mhi = a;
        else if (op == MTLO) mlo = a;
        else begin
            r = model(op, a, b);
            sb.push_back('{r[63:32], r[31:0], cyc + 1 + lat(op, b)});
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL wait_done got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h expected 0", hi); end
        if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h expected 0", lo); end
        if (op_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b expected 1", op_ready); end
        if (hilo_valid !== 1'b1) begin fails++; $display("FAIL reset_hilo_valid got %b expected 1", hilo_valid); end
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        issue(MULT, 32'hFFFFFFFE, 32'h3);
        checks += 2;
        if (op_ready !== 1'b0) begin fails++; $display("FAIL busy_ready got %b expected 0", op_ready); end
        if (hilo_valid !== 1'b0) begin fails++; $display("FAIL busy_hilo_valid got %b expected 0", hilo_valid); end
        wait_done();
        checks++;
        if (hilo_valid !== 1'b1) begin fails++; $display("FAIL post_hilo_valid got %b expected 1", hilo_valid); end
        issue(MULT, 32'hFFFFFFF9, 32'hFFFFFFFD);
        wait_done();
        issue(MULTU, 32'h12345678, 32'h9ABCDEF0);
        wait_done();
        issue(MULT, 32'h80000000, 32'h7FFFFFFF);
        wait_done();
    endtask

    task automatic test_div();
        issue(DIVU, 32'd100, 32'd7);
        wait_done();
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done();
        issue(DIV, 32'd5, 32'd0);
        wait_done();
        issue(DIV, 32'hFFFFFFF9, 32'd0);
        wait_done();
        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done();
        issue(DIVU, 32'd7, 32'h10);
        wait_done();
        issue(DIVU, 32'hFFFFFFFF, 32'd1);
        wait_done();
    endtask

    task automatic test_flush();
        issue(MTHI, 32'h1234, 32'h0);
        checks++;
        if (hi !== 32'h1234) begin fails++; $display("FAIL mthi got %h expected 1234", hi); end
        issue(MTLO, 32'h5678, 32'h0);
        checks++;
        if (lo !== 32'h5678) begin fails++; $display("FAIL mtlo got %h expected 5678", lo); end
        issue(MULTU, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        flush = 1'b0;
        checks += 2;
        if (op_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %b expected 1", op_ready); end
        if (hi !== mhi || lo !== mlo) begin fails++; $display("FAIL flush_hilo got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, mhi, mlo); end
        repeat (40) @(negedge clk);
        op_code = MTHI;
        rs_content = 32'hBEEF;
        op_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if (hi !== 32'h1234) begin fails++; $display("FAIL flush_idle_hi got %h expected 1234", hi); end
        issue(DIV, 32'd5, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        flush = 1'b0;
        checks += 2;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL flush_fixup got hi=%h lo=%h expected hi=1234 lo=5678", hi, lo); end
        if (op_ready !== 1'b1) begin fails++; $display("FAIL flush_fixup_ready got %b expected 1", op_ready); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] r;
        op_code = DIVU;
        rs_content = 32'd1000;
        rt_content = 32'd3;
        op_valid = 1'b1;
        r = model(DIVU, 32'd1000, 32'd3);
        sb.push_back('{r[63:32], r[31:0], cyc + 1 + 33});
        repeat (12) @(negedge clk);
        op_valid = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        issue(DIVU, 32'd50, 32'd5);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        mhi = '0;
        mlo = '0;
        checks += 3;
        if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL midreset_hilo got hi=%h lo=%h expected 0", hi, lo); end
        if (op_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b expected 1", op_ready); end
        if (hilo_valid !== 1'b1) begin fails++; $display("FAIL midreset_hilo_valid got %b expected 1", hilo_valid); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k = 0;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks += 2;
        if (done !== 1'b1) begin fails++; $display("FAIL b2b_done got %b expected 1", done); end
        if (op_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b expected 1", op_ready); end
        issue(DIVU, 32'd1000, 32'd7);
        wait_done();
        checks++;
        if (hi !== 32'd6 || lo !== 32'd142) begin fails++; $display("FAIL b2b_final got hi=%h lo=%h expected hi=6 lo=8e", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
